// File: rtl/crc_stream_pkg.sv
// crc_stream_pkg: FSM state type and CRC helper functions
// shared by the crc_stream engine and its fold sub-module.
package crc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Reverse the low w bits of v.
  function automatic logic [31:0] reflect(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = v;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

  // MSB-first LFSR step over one byte, w-bit register.
  function automatic logic [31:0] crc_step_byte(
    input logic [31:0] crc,
    input logic [7:0]  d,
    input logic [31:0] poly,
    input int          w
  );
    logic [31:0] c;
    logic [31:0] msb;
    logic [31:0] mask;
    logic [7:0]  s;
    logic        fb;
    c    = crc;
    s    = d;
    msb  = 32'd1 << (w - 1);
    mask = (32'd1 << w) - 32'd1;
    for (int i = 0; i < 8; i++) begin
      fb = (|(c & msb)) ^ s[7];
      c  = (c << 1) & mask;
      if (fb) c = c ^ poly;
      s  = {s[6:0], 1'b0};
    end
    return c & mask;
  endfunction

  // Raw register left after a good message plus its CRC:
  // the final XOR pattern, in wire bit order, folded from 0.
  function automatic logic [31:0] residue(
    input logic [31:0] poly,
    input logic [31:0] xorout,
    input int          w,
    input bit          refin
  );
    logic [31:0] r;
    logic [31:0] x;
    logic [31:0] msb;
    logic [31:0] mask;
    logic        fb;
    r    = '0;
    x    = refin ? reflect(xorout, w) : xorout;
    msb  = 32'd1 << (w - 1);
    mask = (32'd1 << w) - 32'd1;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        fb = (|(r & msb)) ^ (|(x & msb));
        r  = (r << 1) & mask;
        x  = x << 1;
        if (fb) r = r ^ poly;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_stream_if.sv
// crc_stream_if: input word stream and result stream of crc_stream.
// master = source/consumer side, slave = engine. CRC_KEEP_EN adds in_keep.
interface crc_stream_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16,
  parameter int LEN_W  = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_first;
  logic              in_last;
  logic              check_mode;
`ifdef CRC_KEEP_EN
  logic [DATA_W/8-1:0] in_keep;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_ok;
  logic [LEN_W-1:0]  out_len;

  modport master (
    output in_valid, in_data, in_first, in_last,
    output check_mode, out_ready,
`ifdef CRC_KEEP_EN
    output in_keep,
`endif
    input  in_ready, out_valid, crc_out, crc_ok, out_len
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last,
    input  check_mode, out_ready,
`ifdef CRC_KEEP_EN
    input  in_keep,
`endif
    output in_ready, out_valid, crc_out, crc_ok, out_len
  );

endinterface

// File: rtl/crc_stream_step.sv
// crc_stream_step: folds one DATA_W word into the CRC register, MSB byte
// first. Ports: crc_in, data, keep (CRC_KEEP_EN only), crc_out.
module crc_stream_step
  import crc_stream_pkg::*;
#(
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021,
  parameter int               DATA_W = 8,
  parameter bit               REFIN  = 1'b0
) (
  input  logic [CRC_W-1:0]    crc_in,
  input  logic [DATA_W-1:0]   data,
`ifdef CRC_KEEP_EN
  input  logic [DATA_W/8-1:0] keep,
`endif
  output logic [CRC_W-1:0]    crc_out
);

  localparam int          NB  = DATA_W / 8;
  localparam logic [31:0] P32 = 32'(POLY);

  logic [31:0] c;
  logic [31:0] r32;
  logic [7:0]  d;

  always_comb begin
    c   = '0;
    r32 = '0;
    d   = '0;
    c[CRC_W-1:0] = crc_in;
    for (int b = NB - 1; b >= 0; b--) begin
      d = data[b*8 +: 8];
      if (REFIN) begin
        r32 = reflect({24'd0, d}, 8);
        d   = r32[7:0];
      end
`ifdef CRC_KEEP_EN
      if (keep[b]) c = crc_step_byte(c, d, P32, CRC_W);
`else
      c = crc_step_byte(c, d, P32, CRC_W);
`endif
    end
    crc_out = c[CRC_W-1:0];
  end

endmodule

// File: rtl/crc_stream.sv
// crc_stream: framed streaming CRC engine with held result and residue check.
// Ports: clk, rst (async, active low), bus (crc_stream_if.slave). Macro CRC_KEEP_EN
// enables the last-word byte mask; out_len then counts bytes, not words.
module crc_stream
  import crc_stream_pkg::*;
#(
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021,
  parameter logic [CRC_W-1:0] INIT   = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOROUT = 16'h0000,
  parameter int               DATA_W = 8,
  parameter bit               REFIN  = 1'b0,
  parameter bit               REFOUT = 1'b0,
  parameter int               LEN_W  = 16
) (
  input logic         clk,
  input logic         rst,
  crc_stream_if.slave bus
);

  localparam int          NB    = DATA_W / 8;
  localparam int          LW1   = LEN_W + 1;
  localparam logic [31:0] RES32 =
    residue(32'(POLY), 32'(XOROUT), CRC_W, REFIN);
  localparam logic [CRC_W-1:0] RES = RES32[CRC_W-1:0];

  state_t state_q, state_d;

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] base;
  logic [CRC_W-1:0] step_out;
  logic [CRC_W-1:0] fin;
  logic [31:0]      fin32;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_base;
  logic [LEN_W-1:0] cnt_d;
  logic [LW1-1:0]   inc;
  logic [LW1-1:0]   sum;
  logic             chk_q;
  logic             chk_d;
  logic [CRC_W-1:0] res_crc_q;
  logic             res_ok_q;
  logic [LEN_W-1:0] res_len_q;
  logic             in_ready;
  logic             acc;
  logic             fold;
  logic             cap;

  assign in_ready = (state_q == DONE) ? bus.out_ready : 1'b1;
  assign acc      = bus.in_valid & in_ready;
  // Outside a frame only a first word is folded; others are dropped.
  assign fold     = acc & (bus.in_first | (state_q == RUN));
  assign cap      = fold & bus.in_last;

  assign base     = bus.in_first ? INIT : crc_q;
  assign cnt_base = bus.in_first ? '0 : cnt_q;
  assign chk_d    = bus.in_first ? bus.check_mode : chk_q;

`ifdef CRC_KEEP_EN
  logic [NB-1:0] keep_eff;

  always_comb begin
    keep_eff = '1;
    if (bus.in_last && (bus.in_keep != '0)) keep_eff = bus.in_keep;
    inc = '0;
    for (int i = 0; i < NB; i++) inc = inc + LW1'(keep_eff[i]);
  end
`else
  assign inc = LW1'(1);
`endif

  assign sum   = {1'b0, cnt_base} + inc;
  assign cnt_d = sum[LEN_W] ? '1 : sum[LEN_W-1:0];

  crc_stream_step #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W),
    .REFIN  (REFIN)
  ) u_step (
    .crc_in  (base),
    .data    (bus.in_data),
`ifdef CRC_KEEP_EN
    .keep    (keep_eff),
`endif
    .crc_out (step_out)
  );

  always_comb begin
    fin32 = '0;
    fin32[CRC_W-1:0] = step_out;
    if (REFOUT) fin32 = reflect(fin32, CRC_W);
    fin = fin32[CRC_W-1:0] ^ XOROUT;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc && bus.in_first)
          state_d = bus.in_last ? DONE : RUN;
      end
      RUN: begin
        if (acc && bus.in_last) state_d = DONE;
      end
      DONE: begin
        // A first word taken with the result handshake starts
        // the next frame without a bubble.
        if (bus.out_ready) begin
          if (acc && bus.in_first)
            state_d = bus.in_last ? DONE : RUN;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q     <= INIT;
      cnt_q     <= '0;
      chk_q     <= 1'b0;
      res_crc_q <= '0;
      res_ok_q  <= 1'b0;
      res_len_q <= '0;
    end else begin
      if (fold) begin
        crc_q <= step_out;
        cnt_q <= cnt_d;
        chk_q <= chk_d;
      end
      if (cap) begin
        res_crc_q <= fin;
        res_ok_q  <= chk_d && (step_out == RES);
        res_len_q <= cnt_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.crc_out   = res_crc_q;
  assign bus.crc_ok    = res_ok_q;
  assign bus.out_len   = res_len_q;

endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: directed and random frames on a CRC-16/8-bit engine and a
// CRC-32/32-bit reflected engine, checked against a bit-serial message model.
module tb_crc_stream;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  crc_stream_if #(.DATA_W(8), .CRC_W(16), .LEN_W(16)) b8 ();
  crc_stream_if #(.DATA_W(32), .CRC_W(32), .LEN_W(16)) b32 ();

  crc_stream u_crc16 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  crc_stream #(
    .CRC_W  (32),
    .POLY   (32'h04C11DB7),
    .INIT   (32'hFFFFFFFF),
    .XOROUT (32'hFFFFFFFF),
    .DATA_W (32),
    .REFIN  (1'b1),
    .REFOUT (1'b1),
    .LEN_W  (16)
  ) u_crc32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  // Message-level reference: expand to a wire-order bit list, then
  // divide bit by bit starting from the preset value.
  function automatic logic [31:0] model(
    input bq_t m, input int w, input logic [31:0] poly,
    input logic [31:0] init, input logic [31:0] xo,
    input bit ri, input bit ro, input bit raw);
    logic [31:0] r, mask, o;
    bit bits[$];
    bit top;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    foreach (m[i])
      for (int k = 0; k < 8; k++)
        bits.push_back(ri ? m[i][k] : m[i][7-k]);
    r = init & mask;
    foreach (bits[j]) begin
      top = r[w-1] ^ bits[j];
      r = (r << 1) & mask;
      if (top) r = r ^ poly;
    end
    if (raw) return r;
    o = r;
    if (ro) begin
      o = '0;
      for (int k = 0; k < w; k++) o[k] = r[w-1-k];
    end
    return (o ^ xo) & mask;
  endfunction

  function automatic logic [15:0] m16(input bq_t m);
    return 16'(model(m, 16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, 1'b0));
  endfunction

  function automatic logic [15:0] raw16(input bq_t m);
    return 16'(model(m, 16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, 1'b1));
  endfunction

  function automatic logic [31:0] m32(input bq_t m);
    return model(m, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic p8(input logic [7:0] d, input bit f, input bit l,
                    input bit cm);
    int n;
    n = 0;
    @(negedge clk);
    b8.in_valid = 1'b1;
    b8.in_data = d;
    b8.in_first = f;
    b8.in_last = l;
    b8.check_mode = cm;
    #1;
    while (b8.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) chk("p8_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
  endtask

  // check_mode is driven only on the first word: the engine must latch it.
  task automatic frame8(input bq_t m, input bit cm);
    for (int i = 0; i < m.size(); i++)
      p8(m[i], i == 0, i == m.size() - 1, cm && (i == 0));
  endtask

  task automatic res8(input string tag, input logic [15:0] c,
                      input bit ok, input logic [15:0] len);
    int n;
    n = 0;
    @(negedge clk);
    while (b8.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 0);
    chk({tag, "_crc"}, b8.crc_out, c);
    chk({tag, "_ok"}, b8.crc_ok, ok);
    chk({tag, "_len"}, b8.out_len, len);
    if (b8.out_ready === 1'b1) begin
      @(negedge clk);
      chk({tag, "_one_cycle"}, b8.out_valid, 0);
    end
  endtask

  task automatic p32(input logic [31:0] d, input bit f, input bit l,
                     input bit cm, input logic [3:0] k);
    int n;
    n = 0;
    @(negedge clk);
    b32.in_valid = 1'b1;
    b32.in_data = d;
    b32.in_first = f;
    b32.in_last = l;
    b32.check_mode = cm;
`ifdef CRC_KEEP_EN
    b32.in_keep = k;
`else
    if (k == 4'hF) b32.in_data = d;
`endif
    #1;
    while (b32.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) chk("p32_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic res32(input string tag, input logic [31:0] c,
                       input bit ok, input logic [15:0] len);
    int n;
    n = 0;
    @(negedge clk);
    while (b32.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 0);
    chk({tag, "_crc"}, b32.crc_out, c);
    chk({tag, "_ok"}, b32.crc_ok, ok);
    chk({tag, "_len"}, b32.out_len, len);
    @(negedge clk);
    chk({tag, "_one_cycle"}, b32.out_valid, 0);
  endtask

  bq_t         msg;
  bq_t         q32;
  logic [15:0] c16;
  logic [31:0] c32;
  logic [31:0] w3;
  int          len;
  bit          cm;

  initial begin
    b8.in_valid = 0;   b8.in_data = '0;  b8.in_first = 0;
    b8.in_last = 0;    b8.check_mode = 0; b8.out_ready = 1;
    b32.in_valid = 0;  b32.in_data = '0; b32.in_first = 0;
    b32.in_last = 0;   b32.check_mode = 0; b32.out_ready = 1;
`ifdef CRC_KEEP_EN
    b8.in_keep = '1;
    b32.in_keep = '1;
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", b8.in_ready, 1);
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_crc_out", b8.crc_out, 0);
    chk("rst_crc_ok", b8.crc_ok, 0);
    chk("rst_out_len", b8.out_len, 0);
    chk("rst32_out_valid", b32.out_valid, 0);
    rst = 1'b1;

    // stray words in IDLE are dropped, then the check string
    p8(8'hAA, 0, 0, 0);
    p8(8'hBB, 0, 1, 0);
    frame8(s2q("123456789"), 0);
    res8("check16", 16'h29B1, 0, 9);

    // residue check: good and corrupted frames
    msg = s2q("123456789");
    msg.push_back(8'h29);
    msg.push_back(8'hB1);
    frame8(msg, 1);
    res8("residue_good", 16'h0000, 1, 11);
    msg[3] = 8'h35;
    frame8(msg, 1);
    res8("residue_bad", m16(msg), 0, 11);

    // result held while the consumer stalls
    b8.out_ready = 0;
    frame8(s2q("AB"), 0);
    res8("hold", m16(s2q("AB")), 0, 2);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", b8.out_valid, 1);
      chk("hold_in_ready", b8.in_ready, 0);
      chk("hold_crc", b8.crc_out, m16(s2q("AB")));
      chk("hold_len", b8.out_len, 2);
    end
    // release together with a new first word: no bubble
    b8.out_ready = 1;
    b8.in_valid = 1;
    b8.in_data = 8'h31;
    b8.in_first = 1;
    b8.in_last = 0;
    b8.check_mode = 0;
    #1;
    chk("b2b_in_ready", b8.in_ready, 1);
    @(posedge clk);
    #1;
    b8.in_valid = 0;
    @(negedge clk);
    chk("b2b_valid_drop", b8.out_valid, 0);
    p8(8'h32, 0, 0, 0);
    p8(8'h33, 0, 1, 0);
    res8("b2b", m16(s2q("123")), 0, 3);

    // a first word mid-frame aborts and restarts
    p8(8'h31, 1, 0, 0);
    p8(8'h32, 0, 0, 0);
    p8(8'h33, 0, 0, 0);
    frame8(s2q("789"), 0);
    res8("abort", m16(s2q("789")), 0, 3);

    // reset while a result is held
    b8.out_ready = 0;
    frame8(s2q("12"), 0);
    res8("pre_rst", m16(s2q("12")), 0, 2);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_done_valid", b8.out_valid, 0);
    chk("rst_done_crc", b8.crc_out, 0);
    chk("rst_done_len", b8.out_len, 0);
    chk("rst_done_ready", b8.in_ready, 1);
    @(negedge clk);
    rst = 1;
    b8.out_ready = 1;

    // reset mid-frame, then a single-word frame
    p8(8'h31, 1, 0, 0);
    p8(8'h32, 0, 0, 0);
    p8(8'h33, 0, 0, 0);
    p8(8'h34, 0, 0, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mid_valid", b8.out_valid, 0);
    @(negedge clk);
    rst = 1;
    msg = {8'h55};
    frame8(msg, 0);
    res8("single55", m16(msg), 0, 1);

    // CRC-32, 32-bit words, reflected
`ifdef CRC_KEEP_EN
    p32(32'h31323334, 1, 0, 0, 4'hF);
    p32(32'h35363738, 0, 0, 0, 4'hF);
    p32(32'h39000000, 0, 1, 0, 4'b1000);
    res32("crc32_keep", 32'hCBF43926, 0, 9);
    p32(32'h31323334, 1, 1, 0, 4'b0000);
    res32("keep_zero", m32(s2q("1234")), 0, 4);
    p32(32'h31323334, 1, 1, 0, 4'b1100);
    res32("keep_two", m32(s2q("12")), 0, 2);
`else
    p32(32'h31323334, 1, 0, 0, 4'hF);
    p32(32'h35363738, 0, 0, 0, 4'hF);
    p32(32'h39000000, 0, 1, 0, 4'hF);
    q32 = s2q("123456789");
    q32.push_back(8'h00);
    q32.push_back(8'h00);
    q32.push_back(8'h00);
    res32("crc32_words", m32(q32), 0, 3);
`endif

    // CRC-32 residue check with the CRC appended low byte first
    q32 = s2q("12345678");
    c32 = m32(q32);
    w3 = {c32[7:0], c32[15:8], c32[23:16], c32[31:24]};
    q32.push_back(c32[7:0]);
    q32.push_back(c32[15:8]);
    q32.push_back(c32[23:16]);
    q32.push_back(c32[31:24]);
    p32(32'h31323334, 1, 0, 1, 4'hF);
    p32(32'h35363738, 0, 0, 0, 4'hF);
    p32(w3, 0, 1, 0, 4'hF);
`ifdef CRC_KEEP_EN
    res32("crc32_res", m32(q32), 1, 12);
`else
    res32("crc32_res", m32(q32), 1, 3);
`endif
    q32[11] = q32[11] ^ 8'h80;
    p32(32'h31323334, 1, 0, 1, 4'hF);
    p32(32'h35363738, 0, 0, 0, 4'hF);
    p32(w3 ^ 32'h00000080, 0, 1, 0, 4'hF);
`ifdef CRC_KEEP_EN
    res32("crc32_res_bad", m32(q32), 0, 12);
`else
    res32("crc32_res_bad", m32(q32), 0, 3);
`endif

    // random frames, gaps and consumer stalls
    for (int t = 0; t < 24; t++) begin
      msg = {};
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      cm = 1'($urandom_range(0, 1));
      if (cm) begin
        c16 = m16(msg);
        msg.push_back(c16[15:8]);
        msg.push_back(c16[7:0]);
        if ($urandom_range(0, 2) == 0) msg[0] = msg[0] ^ 8'h01;
      end
      b8.out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < msg.size(); i++) begin
        repeat ($urandom_range(0, 1)) @(posedge clk);
        p8(msg[i], i == 0, i == msg.size() - 1, cm && (i == 0));
      end
      res8("rnd", m16(msg), cm && (raw16(msg) == 16'h0), 16'(msg.size()));
      if (b8.out_ready !== 1'b1) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          chk("rnd_hold", b8.crc_out, m16(msg));
        end
        b8.out_ready = 1;
        @(negedge clk);
        chk("rnd_release", b8.out_valid, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
